// File: rtl/cdma_gold_spreader_pkg.sv
// cdma_pkg: shared defaults, TX state encoding and sizing helpers for the Gold-code spreader.
package cdma_pkg;
    localparam logic [4:0]  DEF_TAPS1 = 5'b11110;
    localparam logic [4:0]  DEF_TAPS2 = 5'b10010;
    localparam logic [31:0] DEF_SEED  = '1;
    typedef enum logic {TX_IDLE, TX_ACTIVE} tx_state_e;
    function automatic int sf_of(input int w);
        return (1 << w) - 1;
    endfunction
    function automatic int cnt_w(input int sf);
        return $clog2(sf + 1);
    endfunction
endpackage

// File: rtl/cdma_gold_spreader_lfsr.sv
// cdma_lfsr: Fibonacci LFSR that steps on enable, reloads from a seed, and exposes its MSB.
module cdma_lfsr
    import cdma_pkg::*;
#(
    parameter int             W        = 5,
    parameter logic [W-1:0]   TAPS     = W'(DEF_TAPS1),
    parameter logic [W-1:0]   RST_SEED = W'(DEF_SEED)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    output logic         msb_o
);
    logic [W-1:0] r;
    always_ff @(posedge clk_i) begin
        if (rst_i) r <= RST_SEED;
        else if (load_i) r <= seed_i;
        else if (en_i) r <= {r[W-2:0], ^(r & TAPS)};
    end
    assign msb_o = r[W-1];
endmodule

// File: rtl/cdma_gold_spreader.sv
// cdma_gold_spreader: multi-channel Gold-code spreader with symbol framing and valid/ready input.
// Define CDMA_CORR_EN to add the per-channel majority-vote despreading correlator.
module cdma_gold_spreader
    import cdma_pkg::*;
#(
    parameter int           W        = 5,
    parameter int           N_CH     = 2,
    parameter logic [W-1:0] TAPS1    = W'(DEF_TAPS1),
    parameter logic [W-1:0] TAPS2    = W'(DEF_TAPS2),
    parameter logic [W-1:0] RST_SEED = W'(DEF_SEED)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              chip_en_i,
    input  logic              load_i,
    input  logic [W-1:0]      seed1_i,
    input  logic [N_CH*W-1:0] seed2_i,
    output logic              seed_err_o,
    input  logic [N_CH-1:0]   tx_valid_i,
    input  logic [N_CH-1:0]   tx_data_i,
    output logic [N_CH-1:0]   tx_ready_o,
    output logic [N_CH-1:0]   gold_o,
    output logic [N_CH-1:0]   chip_o,
    output logic              sym_start_o,
    input  logic [N_CH-1:0]   rx_chip_i,
    output logic [N_CH-1:0]   rx_valid_o,
    output logic [N_CH-1:0]   rx_data_o
);
    localparam int           SF   = sf_of(W);
    localparam logic [W-1:0] LAST = W'(SF - 1);

    logic            load_ok, bnd, l1;
    logic [N_CH-1:0] l2;
    logic [W-1:0]    chip_cnt;
    tx_state_e       st_q [N_CH];
    tx_state_e       st_d [N_CH];
    logic [N_CH-1:0] buf_full_q, buf_full_d, buf_bit_q, buf_bit_d;
    logic [N_CH-1:0] act_bit_q, act_bit_d, chip_q, chip_d;

    always_comb begin
        seed_err_o = (seed1_i == '0);
        for (int k = 0; k < N_CH; k++) seed_err_o = seed_err_o | (seed2_i[k*W +: W] == '0);
    end

    // A load with a zero seed would lock an LFSR at zero, so it is dropped as a whole.
    assign load_ok = load_i && !seed_err_o;
    assign bnd     = chip_en_i && !load_ok && chip_cnt == LAST;

    cdma_lfsr #(.W(W), .TAPS(TAPS1), .RST_SEED(RST_SEED)) u_lfsr1 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(chip_en_i), .load_i(load_ok),
        .seed_i(seed1_i), .msb_o(l1)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cdma_lfsr #(.W(W), .TAPS(TAPS2), .RST_SEED(RST_SEED)) u_lfsr2 (
            .clk_i(clk_i), .rst_i(rst_i), .en_i(chip_en_i), .load_i(load_ok),
            .seed_i(seed2_i[g*W +: W]), .msb_o(l2[g])
        );
    end

    assign gold_o     = {N_CH{l1}} ^ l2;
    assign tx_ready_o = ~buf_full_q;
    assign chip_o     = chip_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chip_cnt    <= '0;
            sym_start_o <= 1'b0;
        end else begin
            sym_start_o <= bnd;
            if (load_ok) chip_cnt <= '0;
            else if (chip_en_i) chip_cnt <= bnd ? '0 : chip_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            st_d[k]       = st_q[k];
            buf_full_d[k] = buf_full_q[k];
            buf_bit_d[k]  = buf_bit_q[k];
            act_bit_d[k]  = act_bit_q[k];
            chip_d[k]     = chip_q[k];
            if (load_ok) begin
                st_d[k]       = TX_IDLE;
                buf_full_d[k] = 1'b0;
                act_bit_d[k]  = 1'b0;
                chip_d[k]     = 1'b0;
            end else begin
                if (chip_en_i) chip_d[k] = (st_q[k] == TX_ACTIVE) && (act_bit_q[k] ^ gold_o[k]);
                if (bnd) begin
                    st_d[k]       = buf_full_q[k] ? TX_ACTIVE : TX_IDLE;
                    act_bit_d[k]  = buf_full_q[k] ? buf_bit_q[k] : act_bit_q[k];
                    buf_full_d[k] = 1'b0;
                end
            end
            // No bypass: an accepted bit always waits in the buffer for the next boundary.
            if (tx_valid_i[k] && !buf_full_q[k]) begin
                buf_full_d[k] = 1'b1;
                buf_bit_d[k]  = tx_data_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_CH; k++) st_q[k] <= TX_IDLE;
            buf_full_q <= '0;
            buf_bit_q  <= '0;
            act_bit_q  <= '0;
            chip_q     <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) st_q[k] <= st_d[k];
            buf_full_q <= buf_full_d;
            buf_bit_q  <= buf_bit_d;
            act_bit_q  <= act_bit_d;
            chip_q     <= chip_d;
        end
    end

`ifdef CDMA_CORR_EN
    localparam int CW = cnt_w(SF);
    logic [CW-1:0] cnt_q [N_CH];
    logic [CW-1:0] cnt_n [N_CH];

    always_comb begin
        for (int k = 0; k < N_CH; k++) cnt_n[k] = cnt_q[k] + CW'(rx_chip_i[k] ^ gold_o[k]);
    end

    // The boundary chip is folded in via cnt_n before the majority decision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
            rx_valid_o <= '0;
            rx_data_o  <= '0;
        end else begin
            rx_valid_o <= {N_CH{bnd}};
            for (int k = 0; k < N_CH; k++) begin
                if (load_ok) cnt_q[k] <= '0;
                else if (chip_en_i) cnt_q[k] <= bnd ? '0 : cnt_n[k];
                if (bnd) rx_data_o[k] <= cnt_n[k] > CW'(SF / 2);
            end
        end
    end
`else
    logic unused_rx;
    assign unused_rx  = ^rx_chip_i;
    assign rx_valid_o = '0;
    assign rx_data_o  = '0;
`endif
endmodule

// File: tb/tb_cdma_gold_spreader.sv
// tb_cdma_gold_spreader: directed bench with a small reference model of LFSRs, framing and ch0 TX.
module tb_cdma_gold_spreader;
    logic       clk_i = 1'b0, rst_i = 1'b1, chip_en_i = 1'b0, load_i = 1'b0;
    logic [4:0] seed1_i = 5'b00001;
    logic [9:0] seed2_i = {5'b00011, 5'b00001};
    logic [1:0] tx_valid_i = '0, tx_data_i = '0, rx_chip_i = '0;
    logic       seed_err_o, sym_start_o;
    logic [1:0] tx_ready_o, gold_o, chip_o, rx_valid_o, rx_data_o;

    int n_chk = 0, n_pass = 0;
    logic [4:0] m1 = 5'h1f;
    logic [4:0] m2 [2] = '{5'h1f, 5'h1f};
    int mcnt = 0, nflip = 0, pulses = 0;
    int mc [2] = '{0, 0};
    logic mbuf = 0, mbit = 0, mact = 0, mabit = 0;
    logic dq [$];
    int fq [$];
    logic txlog [$];
    logic rxlog [$];
    logic [5:0] gh1 = 6'b101000;

    cdma_gold_spreader dut (
        .clk_i(clk_i), .rst_i(rst_i), .chip_en_i(chip_en_i), .load_i(load_i),
        .seed1_i(seed1_i), .seed2_i(seed2_i), .seed_err_o(seed_err_o),
        .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
        .gold_o(gold_o), .chip_o(chip_o), .sym_start_o(sym_start_o),
        .rx_chip_i(rx_chip_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] st1(input logic [4:0] r);
        return {r[3:0], ^(r & 5'b11110)};
    endfunction

    function automatic logic [4:0] st2(input logic [4:0] r);
        return {r[3:0], ^(r & 5'b10010)};
    endfunction

    task automatic tick(input logic en, input logic ld);
        logic [1:0] g;
        logic ldok, bnd, acc, err, first;
        int nc [2];
        g     = {m1[4] ^ m2[1][4], m1[4] ^ m2[0][4]};
        err   = seed1_i == 0 || seed2_i[4:0] == 0 || seed2_i[9:5] == 0;
        check("seed_err", seed_err_o, err);
        check("gold", gold_o, g);
        check("ready", tx_ready_o, {1'b1, ~mbuf});
        ldok  = ld && !err;
        bnd   = en && !ldok && mcnt == 30;
        acc   = tx_valid_i[0] && !mbuf;
        first = en && !ldok && mact && mcnt == 0;
        rx_chip_i = {1'b0, (mact && (mabit ^ g[0])) ^ (mact && mcnt < nflip)};
        chip_en_i = en;
        load_i    = ld;
        @(posedge clk_i);
        #1;
        chip_en_i = 0;
        load_i    = 0;
        for (int k = 0; k < 2; k++) nc[k] = mc[k] + int'(rx_chip_i[k] ^ g[k]);
        if (ldok) begin
            m1 = seed1_i; m2[0] = seed2_i[4:0]; m2[1] = seed2_i[9:5];
            mcnt = 0; mbuf = 0; mact = 0; mc = '{0, 0};
        end else if (en) begin
            check("chip", chip_o, {1'b0, mact && (mabit ^ g[0])});
            if (first) txlog.push_back(chip_o[0] ^ g[0]);
`ifdef CDMA_CORR_EN
            check("rx_valid", rx_valid_o, {bnd, bnd});
            if (bnd) check("rx_data", rx_data_o, {nc[1] > 15, nc[0] > 15});
            if (bnd && mact) rxlog.push_back(rx_data_o[0]);
`endif
            m1 = st1(m1); m2[0] = st2(m2[0]); m2[1] = st2(m2[1]);
            mcnt = bnd ? 0 : mcnt + 1;
            if (bnd) begin
                mact = mbuf;
                if (mbuf) begin mabit = mbit; nflip = fq.pop_front(); end
                mbuf = 0;
                mc = '{0, 0};
            end else mc = nc;
        end
        if (acc) begin
            mbuf = 1; mbit = tx_data_i[0];
            void'(dq.pop_front());
            if (dq.size() > 0) tx_data_i[0] = dq[0];
            else tx_valid_i[0] = 0;
        end
        check("sym_start", sym_start_o, bnd);
`ifndef CDMA_CORR_EN
        check("rx_off", {rx_valid_o, rx_data_o}, 0);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1, 0);
    endtask

    task automatic send(input logic b, input int f);
        dq.push_back(b);
        fq.push_back(f);
        tx_valid_i[0] = 1;
        tx_data_i[0]  = dq[0];
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        check("rst_chip", chip_o, 0);
        check("rst_ready", tx_ready_o, 2'b11);
        check("rst_sym", sym_start_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_gold", gold_o, 0);
        check("seed_ok", seed_err_o, 0);

        tick(0, 1);
        for (int i = 0; i < 62; i++) begin
            if (i < 6) check("gold_hand", gold_o, {gh1[i], 1'b0});
            tick(1, 0);
            if (sym_start_o) pulses++;
        end
        check("sym_pulses", pulses, 2);

        send(1, 0);
        tick(0, 0);
        check("ready_drop", tx_ready_o, 2'b10);
        run(62);
        check("spread_cnt", txlog.size(), 1);
        check("spread_bit", txlog[0], 1);

        txlog.delete();
        send(1, 0); send(0, 0); send(1, 0);
        run(124);
        check("bp_cnt", txlog.size(), 3);
        check("bp_bit0", txlog[0], 1);
        check("bp_bit1", txlog[1], 0);
        check("bp_bit2", txlog[2], 1);

        run(10);
        seed2_i = {5'd0, 5'b00001};
        #1 check("seed_err_hand", seed_err_o, 1);
        tick(0, 1);
        run(21);
        seed2_i = {5'b00011, 5'b00001};
        seed1_i = 5'd0;
        #1 check("seed1_zero", seed_err_o, 1);
        seed1_i = 5'b00001;
        #1 check("seed_restored", seed_err_o, 0);

        send(1, 0);
        run(41);
        seed1_i = 5'b10101;
        seed2_i = {5'b01100, 5'b00111};
        tick(0, 1);
        check("load_ready", tx_ready_o, 2'b11);
        run(31);

        txlog.delete();
        rxlog.delete();
        send(1, 0); send(1, 15); send(1, 16);
        run(124);
        check("corr_tx_cnt", txlog.size(), 3);
`ifdef CDMA_CORR_EN
        check("corr_cnt", rxlog.size(), 3);
        check("corr_clean", rxlog[0], 1);
        check("corr_15", rxlog[1], 1);
        check("corr_16", rxlog[2], 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
